disp_scan: RTL and testbench
============================

DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles per digit slot, minimum 2.
REQ-003 Port clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port in_valid  in  1  producer offers in_data.
REQ-006 Port in_ready  out  1  block can accept a word.
REQ-007 Port in_data  in  4*NUM_DIGITS  hex word; nibble k drives digit k, digit 0 least significant.
REQ-008 Port lz_blank  in  1  when high, leading-zero suppression is enabled.
REQ-009 Port digit_code  out  8  code for the downstream 7-segment decoder: {4'b0000, nibble}, or 8'h00 when blanked.
REQ-010 Port digit_sel  out  NUM_DIGITS  active-low digit enable, at most one bit low.
REQ-011 Port frame_done  out  1  one-cycle pulse after every completed scan frame.

Function
REQ-012 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; tick is high in the cycle where count == SCAN_DIV-1.
REQ-013 On each tick, digit index idx SHALL advance (idx+1) mod NUM_DIGITS.
REQ-014 Frame boundary: a tick while idx == NUM_DIGITS-1.
REQ-015 Hold registers: disp_reg, the shown word, and pend_reg with flag pend_valid.
REQ-016 in_ready SHALL equal !pend_valid, forced low while reset is high.
REQ-017 Accept: in_valid && in_ready at an edge loads pend_reg and sets pend_valid; in_data SHALL be ignored otherwise.
REQ-018 At a frame boundary with pend_valid set, disp_reg <= pend_reg and pend_valid clears on the same edge.
REQ-019 An accept in a frame-boundary cycle with pend_valid clear SHALL go to pend_reg only; it is displayed from the next frame boundary.
REQ-020 disp_reg SHALL change only at frame boundaries, so a frame never mixes two words.
REQ-021 digit_code and digit_sel SHALL be registered and update on the tick edge to reflect the new idx and the new disp_reg, so there is no extra cycle of latency.
REQ-022 Blanking rule: digit k > 0 is blanked when lz_blank = 1 and nibbles k..NUM_DIGITS-1 of disp_reg are all zero.
REQ-023 Digit 0 is never blanked.
REQ-024 lz_blank SHALL be sampled at each tick edge.
REQ-025 Blanked digit: digit_sel all ones and digit_code 8'h00.
REQ-026 Shown digit k: digit_sel bit k low, all other bits high.
REQ-027 frame_done SHALL be high for exactly the one cycle after each frame-boundary edge.
REQ-028 NUM_DIGITS = 1: every tick is a frame boundary.

Reset
REQ-029 Reset values: prescaler 0, idx 0, disp_reg 0, pend_reg 0, pend_valid 0.
REQ-030 Output reset values: digit_code 8'h00, digit_sel all ones, frame_done 0, in_ready 0.
REQ-031 Reset mid-frame SHALL discard any pending word; the first tick after release occurs SCAN_DIV cycles after reset deasserts.
REQ-032 in_ready SHALL rise the first cycle after reset deasserts.

Structure
REQ-033 Shared package disp_pkg SHALL hold the NUM_DIGITS and SCAN_DIV defaults and the BLANK_CODE (8'h00) constant.
REQ-034 Tick generation SHALL be sub-module scan_prescaler (parameter SCAN_DIV; ports clock, reset, tick).
REQ-035 digit_code connects directly to the downstream 7-segment decoder input; disp_scan contains no segment encoding.

Verification
All scenarios use NUM_DIGITS=4 and SCAN_DIV=4.
REQ-036 Reset, lz_blank=0, no input -> digit_sel cycles 1110, 1101, 1011, 0111 every 4 clocks; digit_code 8'h00 each slot; frame_done pulses every 16 clocks.
REQ-037 Accept 16'h1A3F mid-frame -> in_ready low until the next boundary; the next frame shows codes 0F, 03, 0A, 01 on digits 0..3.
REQ-038 lz_blank=1, word 16'h0050 -> digits 0 and 1 show codes 00 and 05; digits 2 and 3 show digit_sel 1111 with code 00.
REQ-039 Accept 16'h1111, then 16'h2222 held on in_valid -> the second word is held off until the boundary, accepted on the following edge, and displayed one frame later; no frame mixes the two words.
REQ-040 Assert reset during slot 2 with a word pending -> all outputs return to reset values; the pending word is never displayed; first tick 4 cycles after release.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared defaults and constants for the multiplexed hex display scanner.
package disp_pkg;

  localparam int NUM_DIGITS_DEF = 4;
  localparam int SCAN_DIV_DEF   = 50000;

  // Code sent to the 7-segment decoder for a digit that is switched off
  localparam logic [7:0] BLANK_CODE = 8'h00;

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divider that produces one tick per digit slot.
module scan_prescaler
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign tick = (count_q == LAST_COUNT);

  // Count up and wrap back to zero in the tick cycle
  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (tick) begin
      count_d = '0;
    end
  end

  // Counter register, cleared by reset so the first tick lands SCAN_DIV cycles later
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/disp_scan.sv
// Multiplexed hex display scanner: double-buffered word, per-slot digit
// select and code, optional leading-zero blanking, frame-done pulse.
module disp_scan
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int SCAN_DIV   = SCAN_DIV_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_data,
  input  logic                    lz_blank,
  output logic [7:0]              digit_code,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int WORD_W = 4 * NUM_DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic                  tick;
  logic                  boundary;
  logic                  accept;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WORD_W-1:0]     disp_q, disp_d;
  logic [WORD_W-1:0]     pend_q, pend_d;
  logic                  pendValid_q, pendValid_d;
  logic [7:0]            code_q, code_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  frameDone_q, frameDone_d;
  logic                  upperZero;
  logic                  blank;
  logic [3:0]            nibble;

  scan_prescaler #(
    .SCAN_DIV(SCAN_DIV)
  ) uPrescaler (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  assign boundary   = tick && (idx_q == LAST_IDX);
  assign in_ready   = !pendValid_q && !reset;
  assign accept     = in_valid && in_ready;
  assign digit_code = code_q;
  assign digit_sel  = sel_q;
  assign frame_done = frameDone_q;

  // Slot index advance, pending-word handoff at frame boundaries, and input capture
  always_comb begin
    idx_d       = idx_q;
    disp_d      = disp_q;
    pend_d      = pend_q;
    pendValid_d = pendValid_q;
    if (tick) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
    if (boundary && pendValid_q) begin
      disp_d      = pend_q;
      pendValid_d = 1'b0;
    end
    if (accept) begin
      pend_d      = in_data;
      pendValid_d = 1'b1;
    end
  end

  // Outputs for the slot being entered, taken from the word that will be shown in it
  always_comb begin
    code_d      = code_q;
    sel_d       = sel_q;
    frameDone_d = boundary;
    upperZero   = 1'b1;
    blank       = 1'b0;
    nibble      = 4'h0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (disp_d[4*k +: 4] != 4'h0) begin
        upperZero = 1'b0;
      end
      if (k == int'(idx_d)) begin
        nibble = disp_d[4*k +: 4];
        blank  = lz_blank && upperZero && (k != 0);
      end
    end
    if (tick) begin
      sel_d = '1;
      if (blank) begin
        code_d = BLANK_CODE;
      end else begin
        code_d = {4'b0000, nibble};
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (k == int'(idx_d)) begin
            sel_d[k] = 1'b0;
          end
        end
      end
    end
  end

  // State and output registers; reset discards any pending word
  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pendValid_q <= 1'b0;
      code_q      <= BLANK_CODE;
      sel_q       <= '1;
      frameDone_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pendValid_q <= pendValid_d;
      code_q      <= code_d;
      sel_q       <= sel_d;
      frameDone_q <= frameDone_d;
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// Self-checking bench for disp_scan with NUM_DIGITS=4, SCAN_DIV=4:
// directed scenarios followed by randomized traffic against a queue-based model.
module tb_disp_scan;

  localparam int ND = 4;
  localparam int SD = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          inValid = 1'b0;
  logic          inReady;
  logic [4*ND-1:0] inData = '0;
  logic          lzBlank = 1'b0;
  logic [7:0]    digitCode;
  logic [ND-1:0] digitSel;
  logic          frameDone;

  int errorCount = 0;
  int checkCount = 0;

  // Reference model state
  int          mCycles = 0;
  int          mSlot = 0;
  logic [15:0] mShown = '0;
  logic [15:0] mPend[$];
  logic [3:0]  mSel = 4'hF;
  logic [7:0]  mCode = 8'h00;
  logic        mDone = 1'b0;
  logic        lastAccept = 1'b0;

  disp_scan #(
    .NUM_DIGITS(ND),
    .SCAN_DIV  (SD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_data   (inData),
    .lz_blank  (lzBlank),
    .digit_code(digitCode),
    .digit_sel (digitSel),
    .frame_done(frameDone)
  );

  // 10-unit clock period
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at time %0t", tag, observed, expected, $time);
    end
  endtask

  // Expected select/code when the scan enters slot k of the shown word
  task automatic expectDigit(input logic [15:0] word, input int k, input logic lz);
    int rest;
    rest = int'(word) >> (4 * k);
    if (k > 0 && lz && rest == 0) begin
      mSel  = 4'hF;
      mCode = 8'h00;
    end else begin
      mSel    = 4'hF;
      mSel[k] = 1'b0;
      mCode   = 8'(rest % 16);
    end
  endtask

  // One clock edge of the reference model, given the inputs seen at that edge
  task automatic modelStep(input logic r, input logic v, input logic [15:0] d, input logic lz);
    bit tick;
    bit boundary;
    if (r) begin
      mCycles = 0;
      mSlot   = 0;
      mShown  = '0;
      mPend.delete();
      mSel    = 4'hF;
      mCode   = 8'h00;
      mDone   = 1'b0;
      lastAccept = 1'b0;
    end else begin
      tick     = (mCycles % SD) == SD - 1;
      mCycles++;
      boundary = tick && (mSlot == ND - 1);
      lastAccept = v && (mPend.size() == 0);
      if (boundary && mPend.size() > 0) begin
        mShown = mPend.pop_front();
      end
      if (lastAccept) begin
        mPend.push_back(d);
      end
      if (tick) begin
        mSlot = (mSlot + 1) % ND;
        expectDigit(mShown, mSlot, lz);
      end
      mDone = boundary;
    end
  endtask

  // Drive inputs on the falling edge, advance the model on the rising edge, compare shortly after
  task automatic applyStimulus(input logic r, input logic v, input logic [15:0] d, input logic lz);
    @(negedge clock);
    reset   = r;
    inValid = v;
    inData  = d;
    lzBlank = lz;
    @(posedge clock);
    modelStep(r, v, d, lz);
    #1;
    checkOutput("digit_sel", 32'(digitSel), 32'(mSel));
    checkOutput("digit_code", 32'(digitCode), 32'(mCode));
    checkOutput("frame_done", 32'(frameDone), 32'(mDone));
    checkOutput("in_ready", 32'(inReady), 32'(!r && (mPend.size() == 0)));
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 16'($urandom), 1'b0);
    end
  endtask

  task automatic idle(input int n, input logic lz);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 16'($urandom), lz);
    end
  endtask

  // Hold a word on in_valid until it is taken, with a bounded wait
  task automatic sendWord(input logic [15:0] w, input logic lz);
    bit taken;
    taken = 1'b0;
    for (int i = 0; i < 100 && !taken; i++) begin
      applyStimulus(1'b0, 1'b1, w, lz);
      taken = lastAccept;
    end
    checkOutput("acceptTimeout", 32'(taken), 32'd1);
  endtask

  initial begin
    logic [15:0] offer;
    logic [15:0] mask;
    bit          offering;
    logic        lzR;
    logic        rR;

    // Reset state, then idle scanning of a zero word
    doReset(3);
    idle(40, 1'b0);

    // Word accepted mid-frame, shown from the next boundary
    idle(6, 1'b0);
    sendWord(16'h1A3F, 1'b0);
    idle(40, 1'b0);

    // Leading-zero blanking
    sendWord(16'h0050, 1'b1);
    idle(40, 1'b1);

    // Back-to-back words: the second waits for the boundary
    sendWord(16'h1111, 1'b0);
    sendWord(16'h2222, 1'b0);
    idle(40, 1'b0);

    // Reset during slot 2 with a word pending
    for (int i = 0; i < 40 && !frameDone; i++) begin
      idle(1, 1'b0);
    end
    sendWord(16'hBEEF, 1'b0);
    for (int i = 0; i < 40 && digitSel != 4'b1011; i++) begin
      idle(1, 1'b0);
    end
    checkOutput("slot2Reach", 32'(digitSel), 32'h0000000B);
    doReset(2);
    idle(40, 1'b0);

    // Randomized traffic, blanking toggles and occasional resets
    offering = 1'b0;
    offer    = '0;
    lzR      = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      rR = ($urandom_range(0, 299) == 0);
      if (!offering && $urandom_range(0, 19) == 0) begin
        offering = 1'b1;
        case ($urandom_range(0, 4))
          0:       mask = 16'hFFFF;
          1:       mask = 16'h0FFF;
          2:       mask = 16'h00FF;
          3:       mask = 16'h000F;
          default: mask = 16'h0000;
        endcase
        offer = 16'($urandom) & mask;
      end
      if ($urandom_range(0, 9) == 0) begin
        lzR = ~lzR;
      end
      applyStimulus(rR, offering, offering ? offer : 16'($urandom), lzR);
      if (lastAccept) begin
        offering = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
